uart_rx_byte: RTL and testbench



---
 rtl/uart_rx_byte.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_byte.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizes the serial line, centres on each bit with a
// clock-count divider and emits one byte per frame. Define UART_RX_PARITY_EN for 8E1.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_line,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_busy
);

    localparam logic [11:0] LAST    = 12'(CLKS_PER_BIT - 1);
    localparam logic [11:0] HALF_M1 = 12'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [11:0]            cnt_q;
    logic [2:0]             idx_q;
    logic [7:0]             shift_q;
    logic [7:0]             data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   busy_q;
    logic                   rx;
`ifdef UART_RX_PARITY_EN
    logic                   par_q;
    logic                   perr_q;
`endif

    assign rx          = sync_q[SYNC_STAGES-1];
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            sync_q  <= '1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_line};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            cnt_q   <= cnt_q + 12'd1;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    // Re-check mid start bit so short low glitches are dropped
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (rx) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx;
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        par_q   <= rx;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (rx) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (^{shift_q, par_q}) begin
                                perr_q <= 1'b1;
                            end else begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
`else
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`endif
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    cnt_q <= '0;
                    if (rx) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed frames plus random traffic
// checked against a frame-level expectation queue (outcome, byte, strobe cycle).
module tb_uart_rx_byte;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int LAT  = SYNC + 1 + HALF + 10 * CPB;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int LAT  = SYNC + 1 + HALF + 9 * CPB;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int K_VALID = 0, K_FERR = 1, K_PERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_line = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_busy;
    logic       perr;

    int nvec = 0, nerr = 0, cyc = 0;
    int nvalid = 0, nferr = 0, nperr = 0;
    logic [7:0] model_last = 8'h00;
    exp_t q[$];

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_line      (i_line),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(perr),
`endif
        .o_busy      (o_busy)
    );
`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc = cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        nvec++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Every cycle: strobes must match the expectation queue in kind, byte and time.
    always @(negedge i_clk) begin : cmp
        exp_t e;
        if (!i_rst) begin
            chk("strobe_exclusive", 32'(o_valid + o_frame_err + perr) <= 1, 1);
            if (o_valid || o_frame_err || perr) begin
                if (o_valid) nvalid++;
                if (o_frame_err) nferr++;
                if (perr) nperr++;
                if (q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL unexpected_strobe: got v=%0b fe=%0b pe=%0b want none (cycle %0d)",
                             o_valid, o_frame_err, perr, cyc);
                end else begin
                    e = q.pop_front();
                    chk("strobe_kind", o_frame_err ? K_FERR : (perr ? K_PERR : K_VALID), e.kind);
                    nvec++;
                    if (cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
                        nerr++;
                        $display("FAIL strobe_cyc: got %0d want %0d+-1", cyc, e.cyc);
                    end
                    if (e.kind == K_VALID) model_last = e.data;
                end
            end
            chk("o_data_model", o_data, model_last);
            if (q.size() > 0 && cyc > q[0].cyc + 1) begin
                e = q.pop_front();
                nvec++; nerr++;
                $display("FAIL missing_strobe: got none want kind %0d by cycle %0d", e.kind, e.cyc + 1);
            end
        end
    end

    task automatic idle(input int n);
        i_line = 1'b1;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        i_line = b;
        repeat (CPB) @(posedge i_clk);
        #1;
    endtask

    // abort_bit >= 0 asserts reset midway through that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int abort_bit);
        int kind;
        kind = !stop ? K_FERR : ((PAR_EN && (^d ^ par)) ? K_PERR : K_VALID);
        if (abort_bit < 0) q.push_back('{kind, d, cyc + LAT});
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                i_line = d[i];
                repeat (HALF) @(posedge i_clk);
                #1;
                chk("busy_before_abort", o_busy, 1);
                i_rst = 1'b1;
                #1;
                chk("abort_data", o_data, 8'h00);
                chk("abort_valid", o_valid, 0);
                chk("abort_ferr", o_frame_err, 0);
                chk("abort_busy", o_busy, 0);
                q.delete();
                model_last = 8'h00;
                i_line = 1'b1;
                repeat (3) @(posedge i_clk);
                #1;
                i_rst = 1'b0;
                return;
            end
            drive_bit(d[i]);
        end
        if (PAR_EN) drive_bit(par);
        drive_bit(stop);
    endtask

    initial begin
        int f0, v0;
        logic [7:0] d;
        logic stop, par;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_data", o_data, 8'h00);
        chk("rst_valid", o_valid, 0);
        chk("rst_ferr", o_frame_err, 0);
        chk("rst_busy", o_busy, 0);
        i_rst = 1'b0;
        idle(4);

        // Short low glitch must be rejected
        i_line = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        idle(2 * CPB);
        chk("glitch_busy", o_busy, 0);
        chk("glitch_data", o_data, 8'h00);
        chk("glitch_nvalid", nvalid, 0);

        send_frame(8'h55, 1'b1, ^8'h55, -1);
        idle(2);
        chk("f55_data", o_data, 8'h55);
        chk("f55_nvalid", nvalid, 1);
        chk("f55_busy", o_busy, 0);

        // Bad stop bit, then a good frame
        send_frame(8'hA3, 1'b0, ^8'hA3, -1);
        idle(CPB);
        chk("fA3_data_kept", o_data, 8'h55);
        chk("fA3_nferr", nferr, 1);
        send_frame(8'h3C, 1'b1, ^8'h3C, -1);
        idle(CPB);
        chk("f3C_data", o_data, 8'h3C);

        // Line held low for 40 bit times
        f0 = nferr;
        q.push_back('{K_FERR, 8'h00, cyc + LAT});
        i_line = 1'b0;
        repeat (40 * CPB) @(posedge i_clk);
        #1;
        chk("break_busy", o_busy, 1);
        chk("break_nferr", nferr, f0 + 1);
        idle(SYNC + 3);
        chk("break_busy_clr", o_busy, 0);
        chk("break_nferr_after", nferr, f0 + 1);

        // Back-to-back frames, then reset during bit 4 of a third
        v0 = nvalid;
        send_frame(8'h00, 1'b1, 1'b0, -1);
        chk("b2b_first", o_data, 8'h00);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        chk("b2b_second", o_data, 8'hFF);
        chk("b2b_nvalid", nvalid, v0 + 2);
        send_frame(8'h96, 1'b1, ^8'h96, 4);
        v0 = nvalid;
        idle(12 * CPB);
        chk("abort_no_strobe", nvalid, v0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, -1);
        idle(CPB);
        chk("par_good_data", o_data, 8'h07);
        f0 = nperr;
        send_frame(8'h07, 1'b1, 1'b0, -1);
        idle(CPB);
        chk("par_bad_nperr", nperr, f0 + 1);
        chk("par_bad_data", o_data, 8'h07);
`endif

        for (int n = 0; n < 40; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 9) != 0);
            par  = ^d ^ ($urandom_range(0, 4) == 0);
            send_frame(d, stop, par, -1);
            if (!stop)
                idle(CPB * (1 + $urandom_range(0, 2)) + $urandom_range(0, 3));
            else if ($urandom_range(0, 1) == 1)
                idle(CPB * $urandom_range(0, 2) + $urandom_range(0, 3));
        end

        for (int w = 0; w < 2 * LAT && q.size() > 0; w++) @(posedge i_clk);
        idle(4);
        chk("queue_drained", q.size(), 0);
        chk("final_busy", o_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
